tick_period_monitor: RTL

//  Receive-side checker for the timebase strobes (prescaler COUT, CE-gated stage ticks, mod-1000 COUT).

---
 rtl/tick_period_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tick_period_monitor.sv
// Receive-side checker for a periodic strobe: measures CLK cycles between rising
// edges of tick_i, flags early/late intervals, counts errors and tracks lock.
module tick_period_monitor #(
  parameter int WIDTH      = 16,
  parameter int EXPECT     = 103,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] period_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             err_early_o,
  output logic             err_late_o,
  output logic [7:0]       err_count_o
);

  localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int LO     = EXPECT - TOL;
  localparam int HI     = EXPECT + TOL;

  localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [WIDTH-1:0]  LO_CNT    = (LO > 0) ? WIDTH'(LO) : '0;
  localparam logic [WIDTH-1:0]  HI_CNT    = WIDTH'(HI);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic              tick_q;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              late_flag_q, late_flag_d;
  logic [WIDTH-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              early_q, early_d;
  logic              late_q, late_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic tick_edge;
  logic in_window;
  logic is_early;

  assign tick_edge = tick_i & ~tick_q;
  assign in_window = (cnt_q >= LO_CNT) && (cnt_q <= HI_CNT);
  assign is_early  = (cnt_q < LO_CNT);

  // Interval counter: restarts at 1 on an edge so a strobe every N cycles reads N.
  always_comb begin
    if (tick_edge) begin
      cnt_d = WIDTH'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    late_flag_d = late_flag_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    early_d     = 1'b0;
    late_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // First edge only opens the measurement; it has no interval to report.
        if (tick_edge) begin
          state_d     = S_MEASURE;
          good_d      = '0;
          late_flag_d = 1'b0;
        end
      end

      S_MEASURE, S_LOCKED: begin
        if (tick_edge) begin
          period_d    = cnt_q;
          valid_d     = 1'b1;
          late_flag_d = 1'b0;
          if (late_flag_q) begin
            // Interval already reported late: neither good nor early.
            good_d = '0;
          end else if (is_early) begin
            early_d = 1'b1;
            good_d  = '0;
            state_d = S_MEASURE;
          end else if (in_window && state_q == S_MEASURE) begin
            if (good_q == GOOD_LAST) begin
              good_d  = GOOD_FULL;
              state_d = S_LOCKED;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end
        end else if (cnt_q == HI_CNT && !late_flag_q) begin
          late_d      = 1'b1;
          late_flag_d = 1'b1;
          good_d      = '0;
          state_d     = S_MEASURE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign locked_d = (state_d == S_LOCKED);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((early_d || late_d) && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    // tick_q keeps tracking the input through reset so a strobe already high at
    // release is not mistaken for a fresh edge.
    tick_q <= tick_i;
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      good_q      <= '0;
      late_flag_q <= 1'b0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      late_flag_q <= late_flag_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      early_q     <= early_d;
      late_q      <= late_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign period_o    = period_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked_q;
  assign err_early_o = early_q;
  assign err_late_o  = late_q;
  assign err_count_o = err_cnt_q;

endmodule
